// File: rtl/psp_pkg.sv
// rtl/psp_pkg.sv - shared types and widths for the memory-port arbiter
package psp_pkg;

    localparam int XLEN = 32;

    typedef enum logic {
        IDLE,
        WAIT
    } arb_state_t;

    typedef enum logic {
        REQ_I,
        REQ_D
    } req_id_t;

endpackage

// File: rtl/mem_arbiter_if.sv
// rtl/mem_arbiter_if.sv - requester and memory-port signal bundle for mem_arbiter
// Ports: i_req_* / i_resp_* (instruction side), d_req_* / d_resp_* (data side),
//        mem_* (single shared memory port). slave = arbiter view, master = environment view.
interface mem_arbiter_if;
    import psp_pkg::*;

    logic            i_req_valid;
    logic [XLEN-1:0] i_req_addr;
    logic            i_req_ready;
    logic            i_resp_valid;
    logic [XLEN-1:0] i_resp_data;

    logic            d_req_valid;
    logic [XLEN-1:0] d_req_addr;
    logic [XLEN-1:0] d_req_wdata;
    logic            d_req_we;
    logic            d_req_ready;
    logic            d_resp_valid;
    logic [XLEN-1:0] d_resp_data;

    logic [XLEN-1:0] mem_addr;
    logic [XLEN-1:0] mem_data_i;
    logic            mem_data_en;
    logic            mem_write_en;
    logic [XLEN-1:0] mem_data_o;

    modport slave (
        input  i_req_valid, i_req_addr,
        output i_req_ready, i_resp_valid, i_resp_data,
        input  d_req_valid, d_req_addr, d_req_wdata, d_req_we,
        output d_req_ready, d_resp_valid, d_resp_data,
        output mem_addr, mem_data_i, mem_data_en, mem_write_en,
        input  mem_data_o
    );

    modport master (
        output i_req_valid, i_req_addr,
        input  i_req_ready, i_resp_valid, i_resp_data,
        output d_req_valid, d_req_addr, d_req_wdata, d_req_we,
        input  d_req_ready, d_resp_valid, d_resp_data,
        input  mem_addr, mem_data_i, mem_data_en, mem_write_en,
        output mem_data_o
    );

endinterface

// File: rtl/rr_arb2.sv
// rtl/rr_arb2.sv - two-way round-robin grant with registered last-grant pointer
// Ports: clk, reset (sync, active high), req_i/req_d (requests), accept (grant taken),
//        grant_valid/grant_id (combinational winner).
module rr_arb2
    import psp_pkg::*;
(
    input  logic    clk,
    input  logic    reset,
    input  logic    req_i,
    input  logic    req_d,
    input  logic    accept,
    output logic    grant_valid,
    output req_id_t grant_id
);

    req_id_t last_q;
    req_id_t last_d;

    // Pointer starts at I so the first conflict after reset goes to D.
    always_comb begin
        grant_valid = req_i | req_d;
        grant_id    = REQ_I;
        if (req_i && req_d) begin
            grant_id = (last_q == REQ_I) ? REQ_D : REQ_I;
        end else if (req_d) begin
            grant_id = REQ_D;
        end
    end

    // Kept in its own block so accept (derived from grant) does not form a loop.
    always_comb begin
        last_d = last_q;
        if (accept) begin
            last_d = grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            last_q <= REQ_I;
        end else begin
            last_q <= last_d;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// rtl/mem_arbiter.sv - serialises I-side and D-side misses onto one memory port
// Ports: clk, reset (sync, active high), bus (mem_arbiter_if.slave: both requester
//        channels plus the shared memory port). MEM_LATENCY = issue-to-data cycles (1..15).
module mem_arbiter
    import psp_pkg::*;
#(
    parameter int MEM_LATENCY = 1
) (
    input  logic          clk,
    input  logic          reset,
    mem_arbiter_if.slave  bus
);

    localparam logic [3:0] LAT = 4'(MEM_LATENCY);

    arb_state_t state_q, state_d;
    req_id_t    owner_q, owner_d;
    logic       we_q, we_d;
    logic [3:0] cnt_q, cnt_d;

    logic    grant_valid;
    req_id_t grant_id;
    logic    accept;
    logic    resp_fire;

    rr_arb2 u_rr_arb2 (
        .clk         (clk),
        .reset       (reset),
        .req_i       (bus.i_req_valid),
        .req_d       (bus.d_req_valid),
        .accept      (accept),
        .grant_valid (grant_valid),
        .grant_id    (grant_id)
    );

    // Reset gates every strobe so nothing leaks out while reset is held.
    assign accept    = (state_q == IDLE) && grant_valid && !reset;
    assign resp_fire = (state_q == WAIT) && (cnt_q == 4'd1) && !reset;

    always_comb begin
        state_d          = state_q;
        owner_d          = owner_q;
        we_d             = we_q;
        cnt_d            = cnt_q;
        bus.i_req_ready  = 1'b0;
        bus.d_req_ready  = 1'b0;
        bus.i_resp_valid = 1'b0;
        bus.i_resp_data  = '0;
        bus.d_resp_valid = 1'b0;
        bus.d_resp_data  = '0;
        bus.mem_addr     = '0;
        bus.mem_data_i   = '0;
        bus.mem_data_en  = 1'b0;
        bus.mem_write_en = 1'b0;

        if (accept) begin
            bus.mem_data_en = 1'b1;
            state_d         = WAIT;
            owner_d         = grant_id;
            cnt_d           = LAT;
            if (grant_id == REQ_D) begin
                bus.d_req_ready  = 1'b1;
                bus.mem_addr     = bus.d_req_addr;
                bus.mem_data_i   = bus.d_req_wdata;
                bus.mem_write_en = bus.d_req_we;
                we_d             = bus.d_req_we;
            end else begin
                bus.i_req_ready = 1'b1;
                bus.mem_addr    = bus.i_req_addr;
                we_d            = 1'b0;
            end
        end

        if (state_q == WAIT) begin
            cnt_d = cnt_q - 4'd1;
            if (cnt_q == 4'd1) begin
                state_d = IDLE;
            end
        end

        // Read data is passed straight through from memory on the response cycle.
        if (resp_fire) begin
            if (owner_q == REQ_I) begin
                bus.i_resp_valid = 1'b1;
                bus.i_resp_data  = bus.mem_data_o;
            end else begin
                bus.d_resp_valid = 1'b1;
                bus.d_resp_data  = we_q ? '0 : bus.mem_data_o;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            owner_q <= REQ_I;
            we_q    <= 1'b0;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            we_q    <= we_d;
            cnt_q   <= cnt_d;
        end
    end

endmodule

// File: tb/tb_mem_arbiter.sv
// tb/tb_mem_arbiter.sv - scoreboard bench for mem_arbiter at latency 1 and 3
module tb_mem_arbiter;
    import psp_pkg::*;

    typedef struct {
        logic [31:0] data;
        int          cyc;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst1, rst3;
    int   n_vec, n_err, cyc, exit_cnt;
    exp_t q_i1[$], q_d1[$], q_i3[$], q_d3[$];
    logic gq[$];
    int   en3_log[$];

    mem_arbiter_if bus1();
    mem_arbiter_if bus3();

    mem_arbiter #(.MEM_LATENCY(1)) u1 (.clk(clk), .reset(rst1), .bus(bus1));
    mem_arbiter #(.MEM_LATENCY(3)) u3 (.clk(clk), .reset(rst3), .bus(bus3));

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [31:0] init_val(input logic [7:0] i);
        return (i == 8'h04) ? 32'hDEAD_BEEF : (32'hC0DE_0000 | {24'h0, i});
    endfunction

    // Memory models: write at issue edge, read data held from latched address.
    logic [31:0] mem1 [0:255];
    logic [31:0] mem3 [0:255];
    logic [255:0] wr1, wr3;
    logic [31:0] ra1, ra3;

    always @(posedge clk) begin
        if (rst1) wr1 <= '0;
        else if (bus1.mem_data_en) begin
            if (bus1.mem_write_en) begin
                mem1[bus1.mem_addr[9:2]] <= bus1.mem_data_i;
                wr1[bus1.mem_addr[9:2]]  <= 1'b1;
            end
            ra1 <= bus1.mem_addr;
        end
        if (rst3) wr3 <= '0;
        else if (bus3.mem_data_en) begin
            if (bus3.mem_write_en) begin
                mem3[bus3.mem_addr[9:2]] <= bus3.mem_data_i;
                wr3[bus3.mem_addr[9:2]]  <= 1'b1;
            end
            ra3 <= bus3.mem_addr;
        end
    end

    assign bus1.mem_data_o = wr1[ra1[9:2]] ? mem1[ra1[9:2]] : init_val(ra1[9:2]);
    assign bus3.mem_data_o = wr3[ra3[9:2]] ? mem3[ra3[9:2]] : init_val(ra3[9:2]);

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic int qsize(input int k);
        case (k)
            0: return q_i1.size();
            1: return q_d1.size();
            2: return q_i3.size();
            default: return q_d3.size();
        endcase
    endfunction

    function automatic exp_t qpop(input int k);
        case (k)
            0: return q_i1.pop_front();
            1: return q_d1.pop_front();
            2: return q_i3.pop_front();
            default: return q_d3.pop_front();
        endcase
    endfunction

    task automatic qpush(input int k, input logic [31:0] d, input int c);
        exp_t e;
        e.data = d;
        e.cyc  = c;
        case (k)
            0: q_i1.push_back(e);
            1: q_d1.push_back(e);
            2: q_i3.push_back(e);
            default: q_d3.push_back(e);
        endcase
    endtask

    task automatic mon(input int k, input logic v, input logic [31:0] d);
        exp_t e;
        if (v === 1'b1) begin
            if (qsize(k) == 0) begin
                chk($sformatf("unexpected_resp_q%0d", k), 1, 0);
            end else begin
                e = qpop(k);
                chk($sformatf("resp_data_q%0d", k), d, e.data);
                chk($sformatf("resp_cycle_q%0d", k), cyc, e.cyc);
            end
        end
    endtask

    // Response / grant monitor, decoupled from stimulus.
    always @(negedge clk) begin
        mon(0, bus1.i_resp_valid, bus1.i_resp_data);
        mon(1, bus1.d_resp_valid, bus1.d_resp_data);
        mon(2, bus3.i_resp_valid, bus3.i_resp_data);
        mon(3, bus3.d_resp_valid, bus3.d_resp_data);
        if (bus1.i_req_ready || bus1.d_req_ready) begin
            chk("single_ready", bus1.i_req_ready & bus1.d_req_ready, 0);
            if (gq.size() > 0) chk("grant_order_is_d", bus1.d_req_ready, gq.pop_front());
        end
        if (bus1.mem_write_en && bus1.mem_addr == 32'h600d_600d) exit_cnt <= exit_cnt + 1;
        if (bus3.mem_data_en) en3_log.push_back(cyc);
    end

    task automatic set_req(input int inst, input bit d, input bit v, input bit we,
                           input logic [31:0] a, input logic [31:0] w);
        if (inst == 1) begin
            if (d) begin
                bus1.d_req_valid = v; bus1.d_req_we = we; bus1.d_req_addr = a; bus1.d_req_wdata = w;
            end else begin
                bus1.i_req_valid = v; bus1.i_req_addr = a;
            end
        end else begin
            if (d) begin
                bus3.d_req_valid = v; bus3.d_req_we = we; bus3.d_req_addr = a; bus3.d_req_wdata = w;
            end else begin
                bus3.i_req_valid = v; bus3.i_req_addr = a;
            end
        end
    endtask

    function automatic logic get_rdy(input int inst, input bit d);
        if (inst == 1) return d ? bus1.d_req_ready : bus1.i_req_ready;
        return d ? bus3.d_req_ready : bus3.i_req_ready;
    endfunction

    // Called just after a rising edge; returns just after the handshake edge.
    task automatic xfer(input int inst, input bit d, input bit we, input logic [31:0] a,
                        input logic [31:0] w, input logic [31:0] exp, output int t);
        bit got = 0;
        t = -1;
        set_req(inst, d, 1'b1, we, a, w);
        for (int n = 0; n < 40 && !got; n++) begin
            @(negedge clk);
            if (get_rdy(inst, d)) begin
                got = 1;
                t   = cyc;
                qpush(((inst == 3) ? 2 : 0) + int'(d), exp, cyc + inst);
            end
        end
        if (!got) chk("accept_timeout", 0, 1);
        @(posedge clk); #1;
        set_req(inst, d, 1'b0, 1'b0, '0, '0);
    endtask

    task automatic chk_zero(input int inst);
        if (inst == 1) begin
            chk("rst_ctrl1", {bus1.i_req_ready, bus1.d_req_ready, bus1.i_resp_valid,
                              bus1.d_resp_valid, bus1.mem_data_en, bus1.mem_write_en}, 0);
            chk("rst_mem1", {bus1.mem_addr, bus1.mem_data_i}, 0);
            chk("rst_resp1", {bus1.i_resp_data, bus1.d_resp_data}, 0);
        end else begin
            chk("rst_ctrl3", {bus3.i_req_ready, bus3.d_req_ready, bus3.i_resp_valid,
                              bus3.d_resp_valid, bus3.mem_data_en, bus3.mem_write_en}, 0);
            chk("rst_mem3", {bus3.mem_addr, bus3.mem_data_i}, 0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t1, t2, t3;
        bit got;
        rst1 = 1'b1; rst3 = 1'b1;
        set_req(1, 0, 0, 0, '0, '0); set_req(1, 1, 0, 0, '0, '0);
        set_req(3, 0, 0, 0, '0, '0); set_req(3, 1, 0, 0, '0, '0);
        // Both requesters present during reset: nothing may come out.
        set_req(1, 0, 1, 0, 32'h100, '0);
        set_req(1, 1, 1, 0, 32'h200, '0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk_zero(1);
        chk_zero(3);
        for (int k = 0; k < 8; k++) gq.push_back(k % 2 == 0);
        @(posedge clk); #1;
        rst1 = 1'b0; rst3 = 1'b0;

        // Simultaneous streams: D wins first conflict, then strict alternation.
        fork
            begin
                int ta;
                for (int k = 0; k < 4; k++)
                    xfer(1, 0, 0, 32'h100 + 32'(4 * k), '0, 32'hC0DE_0040 + 32'(k), ta);
            end
            begin
                int tb;
                for (int k = 0; k < 4; k++)
                    xfer(1, 1, 0, 32'h200 + 32'(4 * k), '0, 32'hC0DE_0080 + 32'(k), tb);
            end
        join
        chk("grants_consumed", gq.size(), 0);
        repeat (3) @(posedge clk); #1;

        // Lone I read.
        xfer(1, 0, 0, 32'h0000_0010, '0, 32'hDEAD_BEEF, t1);

        // D write then read-back; read raised during WAIT is accepted at T+2.
        xfer(1, 1, 1, 32'h0000_0040, 32'h1234_5678, 32'h0, t1);
        xfer(1, 1, 0, 32'h0000_0040, '0, 32'h1234_5678, t2);
        chk("rd_after_wr_accept", t2, t1 + 2);

        // Exit-address write goes through untouched.
        xfer(1, 1, 1, 32'h600d_600d, 32'h0000_0001, 32'h0, t1);
        repeat (2) @(negedge clk);
        chk("exit_write_cycles", exit_cnt, 1);
        @(posedge clk); #1;

        // Reset right after an accept: response dropped, re-issue completes.
        set_req(1, 0, 1, 0, 32'h10, '0);
        got = 0;
        for (int n = 0; n < 20 && !got; n++) begin
            @(negedge clk);
            if (bus1.i_req_ready) got = 1;
        end
        chk("rst_test_accept", got, 1);
        @(posedge clk); #1;
        rst1 = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk_zero(1);
        end
        @(posedge clk); #1;
        rst1 = 1'b0;
        xfer(1, 0, 0, 32'h10, '0, 32'hDEAD_BEEF, t1);

        // Latency 3: response at T+3, second request from T+1 accepted at T+4.
        set_req(3, 0, 1, 0, 32'h10, '0);
        t3 = -1;
        for (int n = 0; n < 20 && t3 < 0; n++) begin
            @(negedge clk);
            if (bus3.i_req_ready) begin
                t3 = cyc;
                qpush(2, 32'hDEAD_BEEF, cyc + 3);
            end
        end
        chk("l3_first_accept", t3 >= 0, 1);
        @(posedge clk); #1;
        set_req(3, 0, 0, 0, '0, '0);
        xfer(3, 1, 0, 32'h44, '0, 32'hC0DE_0011, t2);
        chk("l3_second_accept", t2, t3 + 4);
        repeat (6) @(negedge clk);
        chk("l3_en_count", en3_log.size(), 2);
        if (en3_log.size() == 2) begin
            chk("l3_en_first", en3_log[0], t3);
            chk("l3_en_second", en3_log[1], t3 + 4);
        end

        chk("q_i1_empty", q_i1.size(), 0);
        chk("q_d1_empty", q_d1.size(), 0);
        chk("q_i3_empty", q_i3.size(), 0);
        chk("q_d3_empty", q_d3.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-requester arbiter that shares one main-memory port between the instruction-side and data-side miss paths. It sits between the caches and `memory`, and replaces the fixed imem/dmem-to-port wiring once both caches refill through a single port. Transactions are serialised one at a time over a valid/ready request channel and a one-cycle response pulse. Round-robin arbitration resolves simultaneous requests.

## Interface
- `MEM_LATENCY`, default 1: cycles from the memory issue cycle to `mem_data_o` valid; legal range 1–15.
- `XLEN`, default 32: address and data width.

Ports:
- `clk`  in  1  system clock; everything is sampled on the rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `i_req_valid`  in  1  instruction-side read request.
- `i_req_addr`  in  XLEN  instruction-side address.
- `i_req_ready`  out  1  instruction-side request accepted this cycle.
- `i_resp_valid`  out  1  one-cycle pulse: `i_resp_data` is valid.
- `i_resp_data`  out  XLEN  instruction-side read data.
- `d_req_valid`  in  1  data-side request.
- `d_req_addr`  in  XLEN  data-side address.
- `d_req_wdata`  in  XLEN  data-side write data.
- `d_req_we`  in  1  1 = write, 0 = read.
- `d_req_ready`  out  1  data-side request accepted this cycle.
- `d_resp_valid`  out  1  one-cycle pulse: data-side read data is valid, or the write is complete.
- `d_resp_data`  out  XLEN  data-side read data; 0 for writes.
- `mem_addr`  out  XLEN  memory address.
- `mem_data_i`  out  XLEN  memory write data.
- `mem_data_en`  out  1  memory access strobe.
- `mem_write_en`  out  1  memory write strobe.
- `mem_data_o`  in  XLEN  memory read data.

## Operation
- FSM states: `IDLE` and `WAIT`.
  - Reset goes to `IDLE`.
  - `IDLE` → `WAIT` on accept.
  - `WAIT` → `IDLE` when the latency counter expires.
- Handshake rules:
  - A requester holds valid and its payload stable until it sees ready.
  - Ready is asserted only in `IDLE`, to at most one requester, in the same cycle as the grant (combinational from the valids).
- Issue cycle (accept cycle): drive `mem_addr`, `mem_data_en` = 1, `mem_write_en` = `d_req_we` for a data grant, and `mem_data_i` = `d_req_wdata`. All four come from a combinational mux of the winning requester.
- The winner's id, `we` and the latency counter are registered at accept.
- Arbitration:
  - A lone request wins.
  - On conflict, the requester not granted last wins.
  - The last-grant pointer updates on every accept and resets to "I", so the first conflict after reset goes to D.
- Response: in the final `WAIT` cycle, the owner's `*_resp_valid` = 1.
  - Read: `*_resp_data` = `mem_data_o`, passed through unregistered.
  - Write: `d_resp_data` = 0.
  - The other side's `*_resp_valid` stays 0.
- Addresses and data pass through unmodified; the arbiter imposes no alignment and applies no address decode. The exit-address write 0x600d600d reaches memory like any other write.
- Reset mid-transaction:
  - The outstanding transaction is dropped and no response is produced.
  - Requesters re-issue after reset.

## Timing
- While `reset` is asserted, the following outputs are 0: both readies, both `*_resp_valid`, `mem_data_en` and `mem_write_en`. Data outputs are 0 as well.
- Accept at cycle T; response at cycle T+`MEM_LATENCY`; FSM back in `IDLE` at T+`MEM_LATENCY`+1.
- Earliest next accept is T+`MEM_LATENCY`+1, so sustained throughput is one transaction per `MEM_LATENCY`+1 cycles.
- In `WAIT`: `mem_data_en` = 0 and `mem_write_en` = 0, and no ready is asserted. A new request arriving during `WAIT` waits.
- A request arriving on the response cycle is accepted on the next cycle, subject to arbitration.
- Latency counter: 4 bits, loaded with `MEM_LATENCY` at accept, decremented in `WAIT`; the response fires when it reaches 1.

## Structure
- Shared package `psp_pkg` holds:
  - `arb_state_t` enum {`IDLE`, `WAIT`};
  - `req_id_t` enum {`REQ_I`, `REQ_D`};
  - `XLEN`.
- One sub-module, `rr_arb2`: 2-way round-robin grant logic with a registered last-grant pointer, advanced by an `accept` input.
- Integrated at the top level in place of the direct imem/dmem port connections. Memory is driven through a single port.

## Test plan
- Lone I read of 0x0000_0010 with `MEM_LATENCY`=1 and memory word 0xDEAD_BEEF:
  - `i_req_ready` at T;
  - `i_resp_valid` with 0xDEAD_BEEF at T+1;
  - `d_resp_valid` stays 0.
- D write of 0x1234_5678 to 0x0000_0040, then D read of the same address:
  - write response at T+1 with `d_resp_data` = 0;
  - read accepted at T+2;
  - read returns 0x1234_5678 at T+3.
- I and D both valid from the cycle after reset, each with 4 transactions:
  - grants are D, I, D, I, D, I, D, I;
  - no response is lost or duplicated.
- `MEM_LATENCY`=3, single read at T:
  - response at T+3 exactly;
  - `mem_data_en` high only at T;
  - a second request raised at T+1 is accepted at T+4.
- `reset` asserted at T+1 after a read accept at T:
  - no `*_resp_valid` at T+1 or later;
  - all outputs 0 during reset;
  - the re-issued request completes normally.
- D write to 0x600d600d:
  - `mem_addr` = 0x600d600d and `mem_write_en` = 1 for exactly one cycle;
  - `d_resp_valid` follows one cycle later.
